// File: rtl/left_shift_sequencer_128_pkg.sv
// left_shift_sequencer_128_pkg: shared state, mode encodings and size defaults
package left_shift_sequencer_128_pkg;
  localparam int DEF_WIDTH = 128;
  localparam int DEF_STEP = 8;
  localparam int DEF_AMT_W = $clog2(DEF_WIDTH);
  localparam logic [1:0] MODE_LSL = 2'd0;
  localparam logic [1:0] MODE_ROL = 2'd1;
  localparam logic [1:0] MODE_FILL = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/left_shift_sequencer_128_step.sv
// left_shift_step: one combinational left shift by 0..STEP with fill or rotate
module left_shift_step
  import left_shift_sequencer_128_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP = DEF_STEP,
  parameter int SW = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic [SW-1:0]    s,
  input  logic             rot,
  input  logic             fill,
  output logic [WIDTH-1:0] q,
  output logic             out_or
);
  logic [WIDTH-1:0] out_bits;
  logic [WIDTH-1:0] mask;
  always_comb begin
    out_bits = d >> (WIDTH - int'(s));
    mask = ~({WIDTH{1'b1}} << s);
    q = (d << s) | (rot ? out_bits : (fill ? mask : '0));
    out_or = |out_bits;
  end
endmodule

// File: rtl/left_shift_sequencer_128.sv
// left_shift_sequencer_128: multi-cycle 128-bit left shift/rotate, falling-edge, valid/ready in and out
module left_shift_sequencer_128
  import left_shift_sequencer_128_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP = DEF_STEP,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] D,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             carry
);
  localparam int SW = $clog2(STEP) + 1;
  state_t state, state_n;
  logic [AMT_W-1:0] rem;
  logic [1:0] mode_r;
  logic fill;
  logic [SW-1:0] s;
  logic [WIDTH-1:0] shifted;
  logic shifted_or;
  assign s = (int'(rem) > STEP) ? SW'(STEP) : SW'(rem);
  left_shift_step #(.WIDTH(WIDTH), .STEP(STEP), .SW(SW)) u_step (
    .d(Q),
    .s(s),
    .rot(mode_r == MODE_ROL),
    .fill(fill),
    .q(shifted),
    .out_or(shifted_or)
  );
  always_ff @(negedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    case (state)
      IDLE: state_n = in_valid ? ((amt == '0) ? DONE : SHIFT) : IDLE;
      SHIFT: state_n = (rem == AMT_W'(s)) ? DONE : SHIFT;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(negedge clock) begin
    if (reset) begin
      Q <= '0;
      carry <= 1'b0;
      rem <= '0;
      mode_r <= MODE_LSL;
      fill <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      Q <= D;
      rem <= amt;
      mode_r <= mode;
      fill <= (mode == MODE_FILL) & D[0];
      carry <= 1'b0;
    end else if (state == SHIFT) begin
      Q <= shifted;
      rem <= rem - AMT_W'(s);
      carry <= carry | (shifted_or & (mode_r != MODE_ROL));
    end
  end
endmodule

// File: tb/tb_left_shift_sequencer_128.sv
// tb_left_shift_sequencer_128: directed and randomized checks against a bitwise reference model
module tb_left_shift_sequencer_128;
  logic clock, reset, in_valid, in_ready, out_valid, out_ready, carry;
  logic [127:0] D, Q;
  logic [6:0] amt;
  logic [1:0] mode;
  int checks = 0;
  int errors = 0;

  left_shift_sequencer_128 dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .amt(amt), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .carry(carry)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic edge_wait();
    @(negedge clock);
    #1;
  endtask

  // Bit-by-bit definition of the whole shift at once: {carry, q}
  function automatic logic [128:0] model(input logic [127:0] d, input int a, input int m);
    logic [127:0] q;
    logic c;
    c = 1'b0;
    for (int i = 0; i < 128; i++) begin
      if (i >= a) q[i] = d[i-a];
      else if (m == 1) q[i] = d[128-a+i];
      else if (m == 2) q[i] = d[0];
      else q[i] = 1'b0;
    end
    for (int i = 128 - a; i < 128; i++) if (m != 1) c = c | d[i];
    return {c, q};
  endfunction

  function automatic int exp_lat(input int a);
    return 1 + (a + 7) / 8;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_op(input logic [127:0] d, input int a, input int m,
                        output logic [127:0] q, output logic c, output int lat);
    in_valid = 1'b1;
    D = d;
    amt = 7'(a);
    mode = 2'(m);
    lat = 0;
    do begin
      edge_wait();
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 300);
    q = Q;
    c = carry;
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    edge_wait();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    D = '1;
    amt = 7'd5;
    mode = 2'd0;
    edge_wait();
    edge_wait();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Q !== '0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b Q=%h carry=%b expected 1 0 0 0", in_ready, out_valid, Q, carry);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    edge_wait();
  endtask

  task automatic test_directed();
    logic [127:0] dv [7];
    int av [7];
    int mv [7];
    logic [127:0] eq [7];
    logic ec [7];
    int el [7];
    logic [127:0] q;
    logic c;
    int lat;
    logic [127:0] ends;
    ends = '0;
    ends[127] = 1'b1;
    ends[0] = 1'b1;
    dv[0] = 128'd1;     av[0] = 127; mv[0] = 0; eq[0] = 128'd1 << 127; ec[0] = 0; el[0] = 17;
    dv[1] = '1;         av[1] = 4;   mv[1] = 0; eq[1] = ~128'hF;       ec[1] = 1; el[1] = 2;
    dv[2] = '1;         av[2] = 4;   mv[2] = 2; eq[2] = '1;            ec[2] = 1; el[2] = 2;
    dv[3] = ends;       av[3] = 1;   mv[3] = 1; eq[3] = 128'h3;        ec[3] = 0; el[3] = 2;
    dv[4] = ends;       av[4] = 9;   mv[4] = 1; eq[4] = 128'h300;      ec[4] = 0; el[4] = 3;
    dv[5] = 128'hDEAD;  av[5] = 0;   mv[5] = 0; eq[5] = 128'hDEAD;     ec[5] = 0; el[5] = 1;
    dv[6] = '1;         av[6] = 4;   mv[6] = 3; eq[6] = ~128'hF;       ec[6] = 1; el[6] = 2;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run_op(dv[i], av[i], mv[i], q, c, lat);
      checks++;
      if (q !== eq[i] || c !== ec[i] || lat != el[i]) begin
        errors++;
        $display("FAIL directed[%0d]: Q=%h carry=%b edges=%0d expected Q=%h carry=%b edges=%0d", i, q, c, lat, eq[i], ec[i], el[i]);
      end
      edge_wait();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_idle[%0d]: in_ready=%b out_valid=%b expected 1 0", i, in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] d, q;
    logic [128:0] e;
    logic c;
    int a, m, lat;
    for (int n = 0; n < 40; n++) begin
      d = rand128();
      a = (n < 4) ? ((n == 0) ? 127 : (n == 1) ? 8 : (n == 2) ? 16 : 7) : int'($urandom_range(0, 127));
      m = int'($urandom_range(0, 3));
      e = model(d, a, m);
      run_op(d, a, m, q, c, lat);
      checks++;
      if (q !== e[127:0] || c !== e[128] || lat != exp_lat(a)) begin
        errors++;
        $display("FAIL random[%0d] amt=%0d mode=%0d: Q=%h carry=%b edges=%0d expected Q=%h carry=%b edges=%0d",
                 n, a, m, q, c, lat, e[127:0], e[128], exp_lat(a));
      end
      release_done();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] d, q, d2;
    logic [128:0] e;
    logic c;
    int lat;
    bit bad;
    d = rand128();
    d2 = rand128();
    e = model(d, 4, 0);
    run_op(d, 4, 0, q, c, lat);
    in_valid = 1'b1;
    D = d2;
    amt = 7'd0;
    mode = 2'd0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      edge_wait();
      if (Q !== e[127:0] || carry !== e[128] || in_ready !== 1'b0 || out_valid !== 1'b1) bad = 1;
    end
    checks++;
    if (bad || lat != 2) begin
      errors++;
      $display("FAIL backpressure_hold: Q=%h carry=%b in_ready=%b out_valid=%b expected Q=%h carry=%b 0 1",
               Q, carry, in_ready, out_valid, e[127:0], e[128]);
    end
    out_ready = 1'b1;
    edge_wait();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Q !== e[127:0]) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b Q=%h expected 1 0 %h", in_ready, out_valid, Q, e[127:0]);
    end
    edge_wait();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || Q !== d2 || carry !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_next: out_valid=%b Q=%h carry=%b expected 1 %h 0", out_valid, Q, carry, d2);
    end
    release_done();
  endtask

  task automatic test_reset_midshift();
    logic [128:0] e;
    int seen;
    in_valid = 1'b1;
    D = '1;
    amt = 7'd100;
    mode = 2'd0;
    edge_wait();
    in_valid = 1'b0;
    edge_wait();
    edge_wait();
    e = model('1, 16, 0);
    checks++;
    if (Q !== e[127:0] || carry !== e[128] || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midshift_progress: Q=%h carry=%b out_valid=%b expected %h %b 0", Q, carry, out_valid, e[127:0], e[128]);
    end
    reset = 1'b1;
    edge_wait();
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Q !== '0 || carry !== 1'b0) begin
      errors++;
      $display("FAIL midshift_reset: in_ready=%b out_valid=%b Q=%h carry=%b expected 1 0 0 0", in_ready, out_valid, Q, carry);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      edge_wait();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midshift_no_output: out_valid high on %0d edges expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d, q;
    logic [128:0] e;
    logic c;
    int a, m, lat;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      d = rand128();
      a = int'($urandom_range(0, 40));
      m = int'($urandom_range(0, 3));
      e = model(d, a, m);
      run_op(d, a, m, q, c, lat);
      checks++;
      if (q !== e[127:0] || c !== e[128] || lat != exp_lat(a)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: Q=%h carry=%b edges=%0d expected Q=%h carry=%b edges=%0d",
                 n, q, c, lat, e[127:0], e[128], exp_lat(a));
      end
      edge_wait();
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back_ready[%0d]: in_ready=%b expected 1", n, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    D = '0;
    amt = '0;
    mode = '0;
    #2;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midshift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/left_shift_sequencer_128.md
# left_shift_sequencer_128

Multi-cycle left-shift/rotate unit for 128-bit operands. It is the left-direction counterpart of the team's falling-edge right-shift register family. An operand and shift amount are accepted on a valid/ready handshake and shifted by at most STEP bit positions per clock. The result is held under a second valid/ready handshake until consumed. It sits between the operand register file and the result writeback path in the DCE06 shift datapath.

## Interface
- WIDTH, 128, operand/result width in bits
- STEP, 8, maximum bit positions shifted per cycle (power of two, 1..WIDTH)
- AMT_W, 7, shift-amount width, clog2(WIDTH)
- clock  input  1  all state updates on the falling edge
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  operand/amount/mode presented
- in_ready  output  1  block can accept; high only in IDLE
- D  input  WIDTH  operand
- amt  input  AMT_W  shift amount, 0..WIDTH-1
- mode  input  2  0 logical (fill 0), 1 rotate left, 2 fill with D[0], 3 reserved (treated as 0)
- out_valid  output  1  result available; high only in DONE
- out_ready  input  1  consumer accepts result
- Q  output  WIDTH  result
- carry  output  1  OR of all bits shifted out of the MSB (modes 0/2); 0 in rotate mode

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1: load Q<=D, rem<=amt, latch mode and fill bit (D[0] for mode 2, else 0), clear carry.
  - Next state is DONE if amt==0, else SHIFT.
- SHIFT: each edge shifts Q left by s=min(rem,STEP) and sets rem<=rem-s.
  - Modes 0/3: vacated LSBs are 0.
  - Mode 2: vacated LSBs are the latched fill bit.
  - Mode 1: the s MSBs wrap into the LSBs.
  - carry |= OR of the s MSBs leaving, except in mode 1.
  - When rem becomes 0, go to DONE.
- DONE: out_valid=1, Q and carry held stable. On an edge with out_ready=1, go to IDLE. A new operand is not accepted on that same edge.
- in_valid outside IDLE is ignored. D, amt and mode are sampled only on the accepting edge.
- Reset (any state): state IDLE, Q=0, carry=0, rem=0, out_valid=0, in_ready=1. An in-flight operation is discarded with no output.
- Reset has priority over in_valid/out_ready on the same edge.

## Timing
- Define k = ceil(amt/STEP).
- out_valid rises after 1+k falling edges counted from and including the accepting edge.
  - amt=0: 1 edge.
  - amt=127, STEP=8: 17 edges.
- Throughput: one operation per 2+k edges at minimum (accept, k shifts, DONE with out_ready already high).
- in_ready and out_valid are decoded combinationally from state only, with no combinational path from inputs.
- Q and carry change only on falling edges.

## Structure
- Shared package holds: the state enum (IDLE/SHIFT/DONE), the mode encoding constants, and WIDTH/AMT_W defaults.
- One sub-module, left_shift_step: combinational shift of WIDTH bits by 0..STEP with fill and rotate select. It outputs the shifted value and the OR of the bits shifted out.
- The top level holds the FSM, the rem counter, and the Q/carry/fill registers.

## Test plan
- Reset, then D=1, amt=127, mode 0, out_ready=1 -> out_valid after 17 edges, Q=1<<127, carry=0, back to IDLE next edge.
- D=all ones, amt=4, mode 0 -> out_valid after 2 edges, Q=0xFFFF...FFF0, carry=1. Same operand with mode 2 -> Q=all ones, carry=1.
- Rotate: D=0x8000...0001, amt=1, mode 1 -> Q=0x0000...0003, carry=0. Also D=0x8000...0001, amt=9, mode 1 -> Q=0x0000...0300 after 3 edges.
- amt=0, D=0xDEAD, mode 0 -> out_valid after 1 edge, Q=0xDEAD, carry=0.
- Backpressure: hold out_ready=0 for 5 edges in DONE while driving in_valid=1 with new D -> Q and carry stable, in_ready=0, new D not loaded. Raise out_ready -> IDLE, then the next in_valid is accepted.
- Assert reset on the 3rd SHIFT edge of amt=100 -> next state IDLE, Q=0, carry=0, out_valid never asserted for that operation.
